load_mem_unit: RTL and testbench
================================

// Module: load_mem_unit
// PURPOSE
//  Memory-access stage downstream of the load buffer; executes one load at a time.
//  - Takes the issued load on read_mem and sends a line read to memory.
//  - Waits for the tagged response, then extracts and sign/zero-extends the addressed bytes.
//  - Broadcasts the result on the CDB under ROB tag; mem_busy back-pressures the load buffer.
// PARAMETERS
//  MEM_TAG_W   4   width of memory transaction tag; tag 0 = "no response"
//  MEM_DATA_W  64  memory line width in bits (8 bytes); address bits [2:0] select byte
// PORTS
//  clock            in   1              system clock
//  reset            in   1              synchronous, active-high reset
//  read_mem         in   1              load buffer issues load this cycle
//  load_address     in   `XLEN          byte address of load
//  load_rob_tag     in   `ROB_TAG_LEN   destination ROB tag
//  load_size        in   2              MEM_SIZE: BYTE=0, HALF=1, WORD=2
//  load_unsigned    in   1              1 = zero-extend, 0 = sign-extend
//  squash           in   1              ROB flush; kill in-flight load
//  mem_busy         out  1              unit cannot accept a load
//  proc2mem_command out  2              BUS_NONE / BUS_LOAD
//  proc2mem_addr    out  `XLEN          line-aligned address {addr[XLEN-1:3],3'b0}
//  mem2proc_response in  MEM_TAG_W      nonzero = request accepted, value = txn tag
//  mem2proc_data    in   MEM_DATA_W     returned line
//  mem2proc_tag     in   MEM_TAG_W      tag of returned data (0 = none)
//  cdb_valid        out  1              result pending on CDB
//  cdb_tag          out  `ROB_TAG_LEN   ROB tag of result
//  cdb_value        out  `XLEN          extended load value
//  cdb_grant        in   1              CDB arbiter accepted result this cycle
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT, DONE, DRAIN. Reset -> IDLE; all registers 0; all outputs 0.
//  - mem_busy = (state != IDLE), combinational. proc2mem_command = BUS_LOAD only in REQ.
//  - IDLE: read_mem=1 latches addr/tag/size/unsigned -> REQ next cycle.
//    read_mem while busy: ignored (protocol violation; assert in sim).
//  - REQ: drive command every cycle until mem2proc_response!=0.
//    On acceptance latch response tag -> WAIT. Retries are unbounded.
//  - WAIT: when mem2proc_tag == saved tag (nonzero), latch extracted value -> DONE.
//    Non-matching tags are ignored.
//  - Extraction:
//    - off=addr[2:0]; BYTE=data[8*off+:8]; HALF=data[8*off+:16]; WORD=data[8*off+:32].
//    - Extend to `XLEN per load_unsigned.
//  - DONE: cdb_valid=1 with stable tag/value until the cycle cdb_grant=1 -> IDLE next cycle.
//    No new load is accepted in the grant cycle.
//  - Load-to-CDB latency (zero-latency memory): read_mem@T, REQ@T+1, WAIT@T+2, DONE@T+3 earliest.
//  - squash priority over all other transitions:
//    - REQ -> IDLE; the command is still driven that cycle.
//    - WAIT -> DRAIN.
//    - DONE -> IDLE; cdb_valid drops next cycle.
//    - IDLE: ignored; read_mem the same cycle is discarded.
//  - DRAIN: mem_busy=1, no CDB. On matching mem2proc_tag -> IDLE and data is dropped.
//  - Reset mid-operation: immediate IDLE; any outstanding memory tag is forgotten.
// CONFIGURATION
//  LOAD_MISALIGN_EXC_EN
//  - Defined:
//    - HALF with addr[0]!=0, or WORD with addr[1:0]!=0, gets no memory request.
//    - IDLE -> DONE directly; cdb_value=0.
//    - Extra output cdb_exception (1 bit) =1 for that result, 0 otherwise.
//  - Undefined: no cdb_exception port.
//    - Misaligned offsets are forced down: HALF off&3'b110, WORD off&3'b100.
//    - Normal memory access.
// STRUCTURE
//  - Shared package (sys_defs):
//    - LMU_STATE enum.
//    - MEM_SIZE enum and BUS_COMMAND enum, if not already present.
//    - LOAD_REQ struct {address, rob_tag, size, unsigned}.
//  - Sub-module load_data_align: combinational extract and extend of (line, offset, size, unsigned) -> `XLEN.
// TESTING
//  - Word load: addr 0x104, WORD, signed; response tag 3 @+2, data tag 3 line 0x8000_0001_xxxx_xxxx
//    -> cdb_value 0x8000_0001, cdb_tag matches.
//  - Byte sign/zero: addr 0x107, line byte7=0xF0 -> signed 0xFFFF_FFF0; unsigned 0x0000_00F0.
//  - Back-pressure: response=0 for 5 cycles -> command held, mem_busy=1; then accept.
//    Also hold cdb_grant=0 for 3 cycles -> outputs stable.
//  - Foreign tag: in WAIT with saved tag 5, tag 2 returns -> ignored; tag 5 next cycle -> DONE.
//  - Squash in WAIT: tag 4 returns 2 cycles later -> no cdb_valid, mem_busy=1 until then, IDLE after.
//  - Misaligned HALF @0x101:
//    - With LOAD_MISALIGN_EXC_EN: no command, cdb_exception=1 within 1 cycle.
//    - Without: byte offset 0 is read.

Source files
------------

// File: rtl/load_mem_unit_pkg.sv
// Shared types for the load memory unit: states, memory sizes, bus commands, load request.
// Optional feature macro used by the unit: LOAD_MISALIGN_EXC_EN.
package sys_defs;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    typedef enum logic [1:0] {
        BYTE = 2'h0,
        HALF = 2'h1,
        WORD = 2'h2
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [2:0] {
        LMU_IDLE,
        LMU_REQ,
        LMU_WAIT,
        LMU_DONE,
        LMU_DRAIN
    } LMU_STATE;

    typedef struct packed {
        logic [XLEN-1:0]        address;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        MEM_SIZE                size;
        logic                   is_unsigned;
    } LOAD_REQ;

    function automatic logic is_misaligned(input MEM_SIZE size, input logic [1:0] low);
        return ((size == HALF) && low[0]) || ((size == WORD) && (low != 2'b00));
    endfunction

endpackage

// File: rtl/load_mem_unit_align.sv
// Combinational byte/half/word extraction from a memory line with sign or zero extension.
module load_data_align
    import sys_defs::*;
#(
    parameter int MEM_DATA_W = 64
) (
    input  logic [MEM_DATA_W-1:0] line,
    input  logic [2:0]            offset,
    input  MEM_SIZE               size,
    input  logic                  is_unsigned,
    output logic [XLEN-1:0]       value
);

    logic [5:0]  byte_base;
    logic [5:0]  half_base;
    logic [5:0]  word_base;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    // Half and word offsets are rounded down so every select stays inside the line.
    assign byte_base = {offset, 3'b000};
    assign half_base = {offset & 3'b110, 3'b000};
    assign word_base = {offset & 3'b100, 3'b000};

    assign byte_v = line[byte_base +: 8];
    assign half_v = line[half_base +: 16];
    assign word_v = line[word_base +: 32];

    always_comb begin
        value = word_v;
        case (size)
            BYTE:    value = {{(XLEN-8){~is_unsigned & byte_v[7]}}, byte_v};
            HALF:    value = {{(XLEN-16){~is_unsigned & half_v[15]}}, half_v};
            default: value = word_v;
        endcase
    end

endmodule

// File: rtl/load_mem_unit.sv
// Single-outstanding load memory stage: line request, tagged response, extract, CDB broadcast.
// Optional LOAD_MISALIGN_EXC_EN turns misaligned loads into immediate exception results.
module load_mem_unit
    import sys_defs::*;
#(
    parameter int MEM_TAG_W  = 4,
    parameter int MEM_DATA_W = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   read_mem,
    input  logic [XLEN-1:0]        load_address,
    input  logic [ROB_TAG_LEN-1:0] load_rob_tag,
    input  logic [1:0]             load_size,
    input  logic                   load_unsigned,
    input  logic                   squash,
    output logic                   mem_busy,
    output logic [1:0]             proc2mem_command,
    output logic [XLEN-1:0]        proc2mem_addr,
    input  logic [MEM_TAG_W-1:0]   mem2proc_response,
    input  logic [MEM_DATA_W-1:0]  mem2proc_data,
    input  logic [MEM_TAG_W-1:0]   mem2proc_tag,
    output logic                   cdb_valid,
    output logic [ROB_TAG_LEN-1:0] cdb_tag,
    output logic [XLEN-1:0]        cdb_value,
`ifdef LOAD_MISALIGN_EXC_EN
    output logic                   cdb_exception,
`endif
    input  logic                   cdb_grant
);

    LMU_STATE              state;
    LMU_STATE              state_next;
    LOAD_REQ               req;
    logic [MEM_TAG_W-1:0]  mem_tag;
    logic [XLEN-1:0]       value;
    logic [XLEN-1:0]       aligned;
    logic                  tag_hit;
    logic                  take_load;
    logic                  take_tag;
    logic                  take_value;
`ifdef LOAD_MISALIGN_EXC_EN
    logic                  exc;
    logic                  misaligned_in;
    assign misaligned_in = is_misaligned(MEM_SIZE'(load_size), load_address[1:0]);
`endif

    assign tag_hit = (mem2proc_tag != '0) && (mem2proc_tag == mem_tag);

    load_data_align #(
        .MEM_DATA_W (MEM_DATA_W)
    ) u_align (
        .line        (mem2proc_data),
        .offset      (req.address[2:0]),
        .size        (req.size),
        .is_unsigned (req.is_unsigned),
        .value       (aligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LMU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Squash is checked first in every busy state; DRAIN only waits out the orphaned response.
    always_comb begin
        state_next = state;
        take_load  = 1'b0;
        take_tag   = 1'b0;
        take_value = 1'b0;
        case (state)
            LMU_IDLE: begin
                if (read_mem && !squash) begin
                    take_load  = 1'b1;
                    state_next = LMU_REQ;
`ifdef LOAD_MISALIGN_EXC_EN
                    if (misaligned_in) begin
                        state_next = LMU_DONE;
                    end
`endif
                end
            end
            LMU_REQ: begin
                if (squash) begin
                    state_next = LMU_IDLE;
                end else if (mem2proc_response != '0) begin
                    take_tag   = 1'b1;
                    state_next = LMU_WAIT;
                end
            end
            LMU_WAIT: begin
                if (squash) begin
                    state_next = LMU_DRAIN;
                end else if (tag_hit) begin
                    take_value = 1'b1;
                    state_next = LMU_DONE;
                end
            end
            LMU_DONE: begin
                if (squash || cdb_grant) begin
                    state_next = LMU_IDLE;
                end
            end
            LMU_DRAIN: begin
                if (tag_hit) begin
                    state_next = LMU_IDLE;
                end
            end
            default: state_next = LMU_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req     <= '0;
            mem_tag <= '0;
            value   <= '0;
`ifdef LOAD_MISALIGN_EXC_EN
            exc     <= 1'b0;
`endif
        end else begin
            if (take_load) begin
                req.address     <= load_address;
                req.rob_tag     <= load_rob_tag;
                req.size        <= MEM_SIZE'(load_size);
                req.is_unsigned <= load_unsigned;
                value           <= '0;
`ifdef LOAD_MISALIGN_EXC_EN
                exc             <= misaligned_in;
`endif
            end
            if (take_tag) begin
                mem_tag <= mem2proc_response;
            end
            if (take_value) begin
                value <= aligned;
            end
        end
    end

    assign mem_busy         = (state != LMU_IDLE);
    assign proc2mem_command = (state == LMU_REQ) ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = {req.address[XLEN-1:3], 3'b000};
    assign cdb_valid        = (state == LMU_DONE);
    assign cdb_tag          = cdb_valid ? req.rob_tag : '0;
    assign cdb_value        = cdb_valid ? value : '0;
`ifdef LOAD_MISALIGN_EXC_EN
    assign cdb_exception    = cdb_valid & exc;
`endif

    busy_load_ignored: assert property (@(posedge clock) disable iff (reset) !(read_mem && mem_busy));

endmodule

// File: tb/tb_load_mem_unit.sv
// Directed bench for load_mem_unit: vector table of complete loads plus multi-cycle corner cases.
// Honours LOAD_MISALIGN_EXC_EN to match the build of the unit under test.
module tb_load_mem_unit;
    import sys_defs::*;

    logic                   clock;
    logic                   reset;
    logic                   read_mem;
    logic [XLEN-1:0]        load_address;
    logic [ROB_TAG_LEN-1:0] load_rob_tag;
    logic [1:0]             load_size;
    logic                   load_unsigned;
    logic                   squash;
    logic                   mem_busy;
    logic [1:0]             proc2mem_command;
    logic [XLEN-1:0]        proc2mem_addr;
    logic [3:0]             mem2proc_response;
    logic [63:0]            mem2proc_data;
    logic [3:0]             mem2proc_tag;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   cdb_grant;
`ifdef LOAD_MISALIGN_EXC_EN
    logic                   cdb_exception;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rob;
        logic [3:0]  mtag;
        logic [63:0] line;
        logic [31:0] expect_value;
    } vec_t;

    vec_t vecs[$];

    load_mem_unit dut (
        .clock             (clock),
        .reset             (reset),
        .read_mem          (read_mem),
        .load_address      (load_address),
        .load_rob_tag      (load_rob_tag),
        .load_size         (load_size),
        .load_unsigned     (load_unsigned),
        .squash            (squash),
        .mem_busy          (mem_busy),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_value         (cdb_value),
`ifdef LOAD_MISALIGN_EXC_EN
        .cdb_exception     (cdb_exception),
`endif
        .cdb_grant         (cdb_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Issue one load; returns at the negedge after the acceptance edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                                 input logic [4:0] rob);
        read_mem      = 1'b1;
        load_address  = addr;
        load_size     = size;
        load_unsigned = uns;
        load_rob_tag  = rob;
        tick();
        read_mem      = 1'b0;
    endtask

    task automatic respond(input logic [3:0] t);
        mem2proc_response = t;
        tick();
        mem2proc_response = 4'd0;
    endtask

    task automatic deliver(input logic [3:0] t, input logic [63:0] line);
        mem2proc_tag  = t;
        mem2proc_data = line;
        tick();
        mem2proc_tag  = 4'd0;
    endtask

    task automatic grant();
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v.addr, v.size, v.uns, v.rob);
        checkOutput("vec_cmd", 32'(proc2mem_command), 32'(BUS_LOAD));
        checkOutput("vec_addr", proc2mem_addr, {v.addr[31:3], 3'b000});
        respond(v.mtag);
        deliver(v.mtag, v.line);
        checkOutput("vec_valid", 32'(cdb_valid), 32'd1);
        checkOutput("vec_value", cdb_value, v.expect_value);
        checkOutput("vec_tag", 32'(cdb_tag), 32'(v.rob));
`ifdef LOAD_MISALIGN_EXC_EN
        checkOutput("vec_exc", 32'(cdb_exception), 32'd0);
`endif
        grant();
        checkOutput("vec_idle", 32'(mem_busy), 32'd0);
        checkOutput("vec_drop", 32'(cdb_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; read_mem = 1'b0; load_address = '0; load_rob_tag = '0;
        load_size = '0; load_unsigned = 1'b0; squash = 1'b0; mem2proc_response = '0;
        mem2proc_data = '0; mem2proc_tag = '0; cdb_grant = 1'b0;

        vecs.push_back('{32'h104, WORD, 1'b0, 5'd9,  4'd3, 64'h8000_0001_1234_5678, 32'h8000_0001});
        vecs.push_back('{32'h107, BYTE, 1'b0, 5'd1,  4'd1, 64'hF000_0000_0000_0000, 32'hFFFF_FFF0});
        vecs.push_back('{32'h107, BYTE, 1'b1, 5'd2,  4'd2, 64'hF000_0000_0000_0000, 32'h0000_00F0});
        vecs.push_back('{32'h102, HALF, 1'b0, 5'd3,  4'd7, 64'h0000_0000_8765_4321, 32'hFFFF_8765});
        vecs.push_back('{32'h206, HALF, 1'b1, 5'd4,  4'd8, 64'hABCD_0000_0000_0000, 32'h0000_ABCD});
        vecs.push_back('{32'h300, WORD, 1'b1, 5'd31, 4'd15, 64'h0000_0000_DEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{32'h103, BYTE, 1'b0, 5'd5,  4'd6, 64'h0000_0000_7F00_0000, 32'h0000_007F});
`ifndef LOAD_MISALIGN_EXC_EN
        vecs.push_back('{32'h101, HALF, 1'b1, 5'd6,  4'd9, 64'h0000_0000_0000_BEEF, 32'h0000_BEEF});
        vecs.push_back('{32'h106, WORD, 1'b0, 5'd7,  4'd10, 64'h1122_3344_5566_7788, 32'h1122_3344});
`endif

        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_busy", 32'(mem_busy), 32'd0);
        checkOutput("rst_cmd", 32'(proc2mem_command), 32'(BUS_NONE));
        checkOutput("rst_addr", proc2mem_addr, 32'd0);
        checkOutput("rst_valid", 32'(cdb_valid), 32'd0);
        checkOutput("rst_tag", 32'(cdb_tag), 32'd0);
        checkOutput("rst_value", cdb_value, 32'd0);

        foreach (vecs[i]) runVector(vecs[i]);

        // Back-pressure on the request and then on the CDB.
        applyStimulus(32'h104, WORD, 1'b0, 5'd12);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_cmd", 32'(proc2mem_command), 32'(BUS_LOAD));
            checkOutput("bp_busy", 32'(mem_busy), 32'd1);
            tick();
        end
        respond(4'd3);
        checkOutput("bp_cmd_off", 32'(proc2mem_command), 32'(BUS_NONE));
        deliver(4'd3, 64'h8000_0001_0000_0000);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_valid", 32'(cdb_valid), 32'd1);
            checkOutput("hold_value", cdb_value, 32'h8000_0001);
            checkOutput("hold_tag", 32'(cdb_tag), 32'd12);
            tick();
        end
        grant();
        checkOutput("bp_idle", 32'(mem_busy), 32'd0);

        // Foreign tag in WAIT is ignored.
        applyStimulus(32'h100, BYTE, 1'b1, 5'd13);
        respond(4'd5);
        deliver(4'd2, 64'h0000_0000_0000_00AA);
        checkOutput("foreign_valid", 32'(cdb_valid), 32'd0);
        checkOutput("foreign_busy", 32'(mem_busy), 32'd1);
        deliver(4'd5, 64'h0000_0000_0000_0055);
        checkOutput("own_valid", 32'(cdb_valid), 32'd1);
        checkOutput("own_value", cdb_value, 32'h0000_0055);
        grant();

        // Squash in WAIT drains the orphaned response.
        applyStimulus(32'h100, WORD, 1'b0, 5'd14);
        respond(4'd4);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("drain_busy", 32'(mem_busy), 32'd1);
            checkOutput("drain_valid", 32'(cdb_valid), 32'd0);
            tick();
        end
        deliver(4'd4, 64'h0000_0000_1234_5678);
        checkOutput("drain_idle", 32'(mem_busy), 32'd0);
        checkOutput("drain_novalid", 32'(cdb_valid), 32'd0);

        // Squash in REQ still drives the command that cycle.
        applyStimulus(32'h100, WORD, 1'b0, 5'd15);
        squash = 1'b1;
        checkOutput("sqreq_cmd", 32'(proc2mem_command), 32'(BUS_LOAD));
        tick();
        squash = 1'b0;
        checkOutput("sqreq_idle", 32'(mem_busy), 32'd0);

        // Squash in DONE drops the result.
        applyStimulus(32'h100, WORD, 1'b0, 5'd16);
        respond(4'd1);
        deliver(4'd1, 64'h0);
        checkOutput("sqdone_valid", 32'(cdb_valid), 32'd1);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        checkOutput("sqdone_drop", 32'(cdb_valid), 32'd0);
        checkOutput("sqdone_idle", 32'(mem_busy), 32'd0);

        // Squash in IDLE discards a simultaneous load.
        squash = 1'b1;
        applyStimulus(32'h100, WORD, 1'b0, 5'd17);
        squash = 1'b0;
        checkOutput("sqidle_busy", 32'(mem_busy), 32'd0);

        // Reset mid-operation forgets the outstanding tag.
        applyStimulus(32'h100, WORD, 1'b0, 5'd18);
        respond(4'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_busy", 32'(mem_busy), 32'd0);
        deliver(4'd6, 64'h0000_0000_1111_2222);
        checkOutput("midrst_late_busy", 32'(mem_busy), 32'd0);
        checkOutput("midrst_late_valid", 32'(cdb_valid), 32'd0);

`ifdef LOAD_MISALIGN_EXC_EN
        // Misaligned half goes straight to an exception result with no memory request.
        read_mem = 1'b1; load_address = 32'h101; load_size = HALF; load_unsigned = 1'b0;
        load_rob_tag = 5'd19;
        checkOutput("mis_cmd_pre", 32'(proc2mem_command), 32'(BUS_NONE));
        tick();
        read_mem = 1'b0;
        checkOutput("mis_cmd", 32'(proc2mem_command), 32'(BUS_NONE));
        checkOutput("mis_valid", 32'(cdb_valid), 32'd1);
        checkOutput("mis_exc", 32'(cdb_exception), 32'd1);
        checkOutput("mis_value", cdb_value, 32'd0);
        checkOutput("mis_tag", 32'(cdb_tag), 32'd19);
        grant();
        checkOutput("mis_idle", 32'(mem_busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
